mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Holds the default widths and starvation limit, plus the arbiter state encoding.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BUSY_IF  = 3'd1,
        BUSY_MEM = 3'd2,
        DONE_IF  = 3'd3,
        DONE_MEM = 3'd4
    } arbState_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch (IF) and a data (MEM) requester onto one shared memory port.
// MEM normally wins; IF is forced through after STARVE_MAX consecutive MEM grants
// made while IF was waiting.
//
// Ports:
//   CLK, Reset                       clock, synchronous active-high reset
//   IF_Req/IF_Addr                   fetch request (held until IF_Done)
//   IF_RData/IF_Done/IF_Stall        fetch result, completion pulse, stall
//   MEM_Req/MEM_Write/MEM_Addr/...   data request (held until MEM_Done)
//   MEM_RData/MEM_Done/MEM_Stall     load result, completion pulse, stall
//   Mem_Valid/Mem_We/Mem_Addr/...    shared-port request
//   Mem_Ready/Mem_RData              shared-port completion and read data
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no access in flight; arbitration happens here
// BUSY_IF  | fetch access on the port, waiting for Mem_Ready
// BUSY_MEM | data access on the port, waiting for Mem_Ready
// DONE_IF  | one-cycle IF_Done pulse, then back to IDLE
// DONE_MEM | one-cycle MEM_Done pulse, then back to IDLE
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              CLK,
    input  logic              Reset,

    input  logic              IF_Req,
    input  logic [ADDR_W-1:0] IF_Addr,
    output logic [DATA_W-1:0] IF_RData,
    output logic              IF_Done,
    output logic              IF_Stall,

    input  logic              MEM_Req,
    input  logic              MEM_Write,
    input  logic [ADDR_W-1:0] MEM_Addr,
    input  logic [DATA_W-1:0] MEM_WData,
    output logic [DATA_W-1:0] MEM_RData,
    output logic              MEM_Done,
    output logic              MEM_Stall,

    output logic              Mem_Valid,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic              Mem_Ready,
    input  logic [DATA_W-1:0] Mem_RData
);

    localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    arbState_t           state;
    arbState_t           stateNext;
    logic [STARVE_W-1:0] starveCnt;
    logic                ifStarved;
    logic                grantIf;
    logic                grantMem;

    assign ifStarved = (starveCnt == STARVE_W'(STARVE_MAX));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        grantIf   = 1'b0;
        grantMem  = 1'b0;
        Mem_Valid = 1'b0;
        IF_Done   = 1'b0;
        MEM_Done  = 1'b0;
        case (state)
            IDLE: begin
                if (MEM_Req && !(IF_Req && ifStarved)) begin
                    grantMem  = 1'b1;
                    stateNext = BUSY_MEM;
                end else if (IF_Req) begin
                    grantIf   = 1'b1;
                    stateNext = BUSY_IF;
                end
            end
            BUSY_IF: begin
                Mem_Valid = 1'b1;
                if (Mem_Ready) stateNext = DONE_IF;
            end
            BUSY_MEM: begin
                Mem_Valid = 1'b1;
                if (Mem_Ready) stateNext = DONE_MEM;
            end
            DONE_IF: begin
                IF_Done   = 1'b1;
                stateNext = IDLE;
            end
            DONE_MEM: begin
                MEM_Done  = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // A requester that is not being served keeps its stall for the whole wait.
    assign IF_Stall  = IF_Req & ~IF_Done;
    assign MEM_Stall = MEM_Req & ~MEM_Done;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            Mem_We    <= 1'b0;
            Mem_Addr  <= '0;
            Mem_WData <= '0;
            IF_RData  <= '0;
            MEM_RData <= '0;
            starveCnt <= '0;
        end else begin
            if (grantMem) begin
                Mem_We    <= MEM_Write;
                Mem_Addr  <= MEM_Addr;
                Mem_WData <= MEM_WData;
            end else if (grantIf) begin
                Mem_We    <= 1'b0;
                Mem_Addr  <= IF_Addr;
                Mem_WData <= '0;
            end

            // Only completions seen in a BUSY state are honoured; stray Ready is ignored.
            if (state == BUSY_IF && Mem_Ready) begin
                IF_RData <= Mem_RData;
            end
            if (state == BUSY_MEM && Mem_Ready && !Mem_We) begin
                MEM_RData <= Mem_RData;
            end

            if (grantIf) begin
                starveCnt <= '0;
            end else if (grantMem && IF_Req && !ifStarved) begin
                starveCnt <= starveCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          IF_Req;
    logic [AW-1:0] IF_Addr;
    logic [DW-1:0] IF_RData;
    logic          IF_Done;
    logic          IF_Stall;
    logic          MEM_Req;
    logic          MEM_Write;
    logic [AW-1:0] MEM_Addr;
    logic [DW-1:0] MEM_WData;
    logic [DW-1:0] MEM_RData;
    logic          MEM_Done;
    logic          MEM_Stall;
    logic          Mem_Valid;
    logic          Mem_We;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_WData;
    logic          Mem_Ready;
    logic [DW-1:0] Mem_RData;

    int testCnt = 0;
    int failCnt = 0;
    int ifDoneCnt = 0;
    int memDoneCnt = 0;
    int snapIf;
    int snapMem;

    mem_port_arbiter dut (
        .CLK(CLK), .Reset(Reset),
        .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_RData(IF_RData),
        .IF_Done(IF_Done), .IF_Stall(IF_Stall),
        .MEM_Req(MEM_Req), .MEM_Write(MEM_Write), .MEM_Addr(MEM_Addr),
        .MEM_WData(MEM_WData), .MEM_RData(MEM_RData),
        .MEM_Done(MEM_Done), .MEM_Stall(MEM_Stall),
        .Mem_Valid(Mem_Valid), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
        .Mem_WData(Mem_WData), .Mem_Ready(Mem_Ready), .Mem_RData(Mem_RData)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (IF_Done === 1'b1) ifDoneCnt <= ifDoneCnt + 1;
        if (MEM_Done === 1'b1) memDoneCnt <= memDoneCnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        IF_Req = 1'b0; IF_Addr = '0;
        MEM_Req = 1'b0; MEM_Write = 1'b0; MEM_Addr = '0; MEM_WData = '0;
        Mem_Ready = 1'b0; Mem_RData = '0;
        tick(); tick();
        Reset = 1'b0;

        // Reset state
        check("rst_state", 64'(dut.state), 64'(IDLE));
        check("rst_valid", 64'(Mem_Valid), 64'd0);
        check("rst_we", 64'(Mem_We), 64'd0);
        check("rst_addr", 64'(Mem_Addr), 64'd0);
        check("rst_wdata", 64'(Mem_WData), 64'd0);
        check("rst_if_rdata", 64'(IF_RData), 64'd0);
        check("rst_mem_rdata", 64'(MEM_RData), 64'd0);
        check("rst_done", 64'({IF_Done, MEM_Done}), 64'd0);
        check("rst_starve", 64'(dut.starveCnt), 64'd0);

        // Single IF read at 0x100, Ready two cycles after Valid
        snapIf = ifDoneCnt;
        IF_Req = 1'b1; IF_Addr = 32'h100;
        #1 check("t1_stall_c0", 64'(IF_Stall), 64'd1);
        tick();
        check("t1_valid_c1", 64'(Mem_Valid), 64'd1);
        check("t1_addr", 64'(Mem_Addr), 64'h100);
        check("t1_we", 64'(Mem_We), 64'd0);
        check("t1_stall_c1", 64'(IF_Stall), 64'd1);
        tick();
        check("t1_valid_c2", 64'(Mem_Valid), 64'd1);
        check("t1_done_c2", 64'(IF_Done), 64'd0);
        tick();
        Mem_Ready = 1'b1; Mem_RData = 32'hE3A00001;
        check("t1_valid_c3", 64'(Mem_Valid), 64'd1);
        check("t1_stall_c3", 64'(IF_Stall), 64'd1);
        tick();
        check("t1_done", 64'(IF_Done), 64'd1);
        check("t1_rdata", 64'(IF_RData), 64'hE3A00001);
        check("t1_valid_off", 64'(Mem_Valid), 64'd0);
        check("t1_stall_done", 64'(IF_Stall), 64'd0);
        Mem_Ready = 1'b0; IF_Req = 1'b0;
        tick();
        check("t1_done_off", 64'(IF_Done), 64'd0);
        check("t1_state_idle", 64'(dut.state), 64'(IDLE));
        check("t1_done_once", 64'(ifDoneCnt - snapIf), 64'd1);

        // MEM read at minimum latency
        MEM_Req = 1'b1; MEM_Write = 1'b0; MEM_Addr = 32'h300;
        tick();
        check("t2_valid", 64'(Mem_Valid), 64'd1);
        check("t2_addr", 64'(Mem_Addr), 64'h300);
        check("t2_we", 64'(Mem_We), 64'd0);
        Mem_Ready = 1'b1; Mem_RData = 32'h11112222;
        tick();
        check("t2_done", 64'(MEM_Done), 64'd1);
        check("t2_rdata", 64'(MEM_RData), 64'h11112222);
        check("t2_if_rdata_kept", 64'(IF_RData), 64'hE3A00001);
        MEM_Req = 1'b0; Mem_Ready = 1'b0;
        tick();

        // Simultaneous requests: MEM store first, then IF
        MEM_Req = 1'b1; MEM_Write = 1'b1; MEM_Addr = 32'h200; MEM_WData = 32'hDEADBEEF;
        IF_Req = 1'b1; IF_Addr = 32'h104;
        tick();
        check("t3_state_mem", 64'(dut.state), 64'(BUSY_MEM));
        check("t3_we", 64'(Mem_We), 64'd1);
        check("t3_addr", 64'(Mem_Addr), 64'h200);
        check("t3_wdata", 64'(Mem_WData), 64'hDEADBEEF);
        check("t3_if_stall", 64'(IF_Stall), 64'd1);
        Mem_Ready = 1'b1; Mem_RData = 32'h55555555;
        tick();
        check("t3_mem_done", 64'(MEM_Done), 64'd1);
        check("t3_mem_rdata_kept", 64'(MEM_RData), 64'h11112222);
        check("t3_starve1", 64'(dut.starveCnt), 64'd1);
        check("t3_if_stall_wait", 64'(IF_Stall), 64'd1);
        MEM_Req = 1'b0; MEM_Write = 1'b0; Mem_Ready = 1'b0;
        tick();
        tick();
        check("t3_state_if", 64'(dut.state), 64'(BUSY_IF));
        check("t3_if_addr", 64'(Mem_Addr), 64'h104);
        check("t3_if_we", 64'(Mem_We), 64'd0);
        check("t3_starve_clr", 64'(dut.starveCnt), 64'd0);
        Mem_Ready = 1'b1; Mem_RData = 32'hCAFEF00D;
        tick();
        check("t3_if_done", 64'(IF_Done), 64'd1);
        check("t3_if_rdata", 64'(IF_RData), 64'hCAFEF00D);
        IF_Req = 1'b0; Mem_Ready = 1'b0;
        tick();

        // Starvation: three MEM grants, then IF wins
        MEM_Req = 1'b1; MEM_Write = 1'b0; MEM_Addr = 32'h500; IF_Req = 1'b1; IF_Addr = 32'h108;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_mem_grant", 64'(dut.state), 64'(BUSY_MEM));
            Mem_Ready = 1'b1; Mem_RData = 32'h1000 + 32'(i);
            tick();
            Mem_Ready = 1'b0;
            tick();
        end
        check("t4_starve3", 64'(dut.starveCnt), 64'd3);
        tick();
        check("t4_if_grant", 64'(dut.state), 64'(BUSY_IF));
        check("t4_if_addr", 64'(Mem_Addr), 64'h108);
        check("t4_starve_clr", 64'(dut.starveCnt), 64'd0);
        check("t4_mem_stall", 64'(MEM_Stall), 64'd1);
        Mem_Ready = 1'b1; Mem_RData = 32'h22223333;
        tick();
        check("t4_if_done", 64'(IF_Done), 64'd1);
        IF_Req = 1'b0; Mem_Ready = 1'b0;
        tick();
        tick();
        check("t4_mem_regrant", 64'(dut.state), 64'(BUSY_MEM));

        // Reset during BUSY_MEM with Ready withheld
        snapMem = memDoneCnt;
        tick();
        check("t5_valid_busy", 64'(Mem_Valid), 64'd1);
        Reset = 1'b1;
        tick();
        check("t5_valid_off", 64'(Mem_Valid), 64'd0);
        check("t5_state", 64'(dut.state), 64'(IDLE));
        check("t5_done", 64'(MEM_Done), 64'd0);
        check("t5_mem_rdata", 64'(MEM_RData), 64'd0);
        check("t5_addr", 64'(Mem_Addr), 64'd0);
        Reset = 1'b0; MEM_Req = 1'b0;
        tick();
        tick();
        check("t5_no_done", 64'(memDoneCnt - snapMem), 64'd0);

        // MEM_Req dropped mid-transaction
        snapMem = memDoneCnt;
        MEM_Req = 1'b1; MEM_Write = 1'b0; MEM_Addr = 32'h400;
        tick();
        check("t6_busy", 64'(dut.state), 64'(BUSY_MEM));
        MEM_Req = 1'b0;
        tick();
        check("t6_still_valid", 64'(Mem_Valid), 64'd1);
        check("t6_stall_low", 64'(MEM_Stall), 64'd0);
        Mem_Ready = 1'b1; Mem_RData = 32'h0BADF00D;
        tick();
        check("t6_done", 64'(MEM_Done), 64'd1);
        check("t6_rdata", 64'(MEM_RData), 64'h0BADF00D);
        Mem_Ready = 1'b0;
        tick();
        tick();
        check("t6_no_regrant", 64'(dut.state), 64'(IDLE));
        check("t6_valid_off", 64'(Mem_Valid), 64'd0);
        check("t6_done_once", 64'(memDoneCnt - snapMem), 64'd1);

        // Stray Ready in IDLE
        snapIf = ifDoneCnt; snapMem = memDoneCnt;
        Mem_Ready = 1'b1; Mem_RData = 32'hFFFF0000;
        tick();
        check("t7_state", 64'(dut.state), 64'(IDLE));
        check("t7_valid", 64'(Mem_Valid), 64'd0);
        Mem_Ready = 1'b0;
        tick();
        check("t7_no_done", 64'((ifDoneCnt - snapIf) + (memDoneCnt - snapMem)), 64'd0);
        check("t7_if_rdata", 64'(IF_RData), 64'd0);
        check("t7_mem_rdata", 64'(MEM_RData), 64'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
